// File: rtl/types_pkg.sv
// rtl/types_pkg.sv - shared dispatch types and sizing constants
package types_pkg;

    localparam int NUM_PREG   = 128;
    localparam int PREG_IDX_W = $clog2(NUM_PREG);
    localparam int NUM_RS     = 3;
    localparam int ROB_IDX_W  = 5;
    localparam int CNT_W      = 16;

    typedef enum logic [1:0] {
        FU_ALU  = 2'd0,
        FU_BR   = 2'd1,
        FU_LSU  = 2'd2,
        FU_NONE = 2'd3
    } fu_type_e;

    typedef struct packed {
        logic [PREG_IDX_W-1:0] pd_new;
        logic [PREG_IDX_W-1:0] ps1;
        logic [PREG_IDX_W-1:0] ps2;
        logic [31:0]           imm;
    } rename_data;

endpackage

// File: rtl/preg_ready_table.sv
// rtl/preg_ready_table.sv - physical-register ready bits with writeback bypass
module preg_ready_table
    import types_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clr_en,
    input  logic [PREG_IDX_W-1:0] clr_preg,
    input  logic                  set_en,
    input  logic [PREG_IDX_W-1:0] set_preg,
    output logic [NUM_PREG-1:0]   rtable
);

    logic [NUM_PREG-1:0] table_q;
    logic [NUM_PREG-1:0] set_mask;

    // Writeback decode, used both for the update and the same-cycle bypass
    always_comb begin
        set_mask = '0;
        for (int i = 0; i < NUM_PREG; i++) begin
            set_mask[i] = set_en && (set_preg == PREG_IDX_W'(i));
        end
    end

    // Clear takes priority over set; preg 0 is hardwired ready
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            table_q <= '1;
        end else begin
            for (int i = 0; i < NUM_PREG; i++) begin
                if (i == 0) begin
                    table_q[i] <= 1'b1;
                end else if (clr_en && (clr_preg == PREG_IDX_W'(i))) begin
                    table_q[i] <= 1'b0;
                end else if (set_mask[i]) begin
                    table_q[i] <= 1'b1;
                end
            end
        end
    end

    assign rtable = table_q | set_mask;

endmodule

// File: rtl/dispatch_unit.sv
// rtl/dispatch_unit.sv - single-entry dispatch buffer steering to RS and ROB
module dispatch_unit
    import types_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rn_valid,
    output logic                  rn_ready,
    input  rename_data            rn_data,
    input  logic [1:0]            rn_fu,
    input  logic [6:0]            rn_opcode,
    input  logic [NUM_RS-1:0]     rs_full,
    output logic [NUM_RS-1:0]     di_en,
    output rename_data            di_data,
    output logic [1:0]            di_fu,
    output logic [6:0]            di_opcode,
    input  logic                  rob_full,
    input  logic [ROB_IDX_W-1:0]  rob_tail,
    output logic                  rob_alloc,
    output logic [ROB_IDX_W-1:0]  di_rob_index,
    input  logic                  wb_valid,
    input  logic [PREG_IDX_W-1:0] wb_preg,
    input  logic                  flush,
    output logic [NUM_PREG-1:0]   preg_rtable,
    output logic [CNT_W-1:0]      dispatched_cnt,
    output logic [CNT_W-1:0]      stall_cnt
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} hold_state_e;

    hold_state_e state_q;
    rename_data  data_q;
    logic [1:0]  fu_q;
    logic [6:0]  opcode_q;
    logic        fire;
    logic        accept;
    logic        rs_blocked;
    logic [3:0]  rs_full_ext;
    logic [3:0]  fu_onehot;

    // Index 3 (no RS) maps to a constant not-full slot
    assign rs_full_ext = {1'b0, rs_full};
    assign rs_blocked  = rs_full_ext[fu_q];
    assign fire        = (state_q == FULL) && !rob_full && !rs_blocked && !flush;
    assign rn_ready    = !flush && ((state_q == EMPTY) || fire);
    assign accept      = rn_valid && rn_ready;

    assign fu_onehot    = 4'b0001 << fu_q;
    assign di_en        = fire ? fu_onehot[NUM_RS-1:0] : '0;
    assign rob_alloc    = fire;
    assign di_data      = data_q;
    assign di_fu        = fu_q;
    assign di_opcode    = opcode_q;
    assign di_rob_index = rob_tail;

    // Holding register: reload on accept, drain on fire or flush
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= EMPTY;
            data_q   <= '0;
            fu_q     <= '0;
            opcode_q <= '0;
        end else if (flush) begin
            state_q <= EMPTY;
        end else if (accept) begin
            state_q  <= FULL;
            data_q   <= rn_data;
            fu_q     <= rn_fu;
            opcode_q <= rn_opcode;
        end else if (fire) begin
            state_q <= EMPTY;
        end
    end

    // Saturating performance counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dispatched_cnt <= '0;
            stall_cnt      <= '0;
        end else begin
            if (fire && (dispatched_cnt != '1)) begin
                dispatched_cnt <= dispatched_cnt + 1'b1;
            end
            if ((state_q == FULL) && !fire && !flush && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end

    preg_ready_table u_ready_table (
        .clk      (clk),
        .reset    (reset),
        .clr_en   (fire && (data_q.pd_new != '0)),
        .clr_preg (data_q.pd_new),
        .set_en   (wb_valid),
        .set_preg (wb_preg),
        .rtable   (preg_rtable)
    );

endmodule

// File: tb/tb_dispatch_unit.sv
// tb/tb_dispatch_unit.sv - directed self-checking bench for dispatch_unit
module tb_dispatch_unit;
    import types_pkg::*;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  rn_valid;
    logic                  rn_ready;
    rename_data            rn_data;
    logic [1:0]            rn_fu;
    logic [6:0]            rn_opcode;
    logic [NUM_RS-1:0]     rs_full;
    logic [NUM_RS-1:0]     di_en;
    rename_data            di_data;
    logic [1:0]            di_fu;
    logic [6:0]            di_opcode;
    logic                  rob_full;
    logic [ROB_IDX_W-1:0]  rob_tail;
    logic                  rob_alloc;
    logic [ROB_IDX_W-1:0]  di_rob_index;
    logic                  wb_valid;
    logic [PREG_IDX_W-1:0] wb_preg;
    logic                  flush;
    logic [NUM_PREG-1:0]   preg_rtable;
    logic [CNT_W-1:0]      dispatched_cnt;
    logic [CNT_W-1:0]      stall_cnt;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    dispatch_unit dut (
        .clk            (clk),
        .reset          (reset),
        .rn_valid       (rn_valid),
        .rn_ready       (rn_ready),
        .rn_data        (rn_data),
        .rn_fu          (rn_fu),
        .rn_opcode      (rn_opcode),
        .rs_full        (rs_full),
        .di_en          (di_en),
        .di_data        (di_data),
        .di_fu          (di_fu),
        .di_opcode      (di_opcode),
        .rob_full       (rob_full),
        .rob_tail       (rob_tail),
        .rob_alloc      (rob_alloc),
        .di_rob_index   (di_rob_index),
        .wb_valid       (wb_valid),
        .wb_preg        (wb_preg),
        .flush          (flush),
        .preg_rtable    (preg_rtable),
        .dispatched_cnt (dispatched_cnt),
        .stall_cnt      (stall_cnt)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Advance one cycle and settle just past the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [1:0] fu, input int pd, input int s1, input int s2);
        rn_valid       = 1'b1;
        rn_fu          = fu;
        rn_data.pd_new = PREG_IDX_W'(pd);
        rn_data.ps1    = PREG_IDX_W'(s1);
        rn_data.ps2    = PREG_IDX_W'(s2);
        rn_data.imm    = 32'h0000_1234;
        rn_opcode      = 7'h33;
    endtask

    initial begin
        reset = 1'b1; rn_valid = 1'b0; rn_data = '0; rn_fu = 2'd0; rn_opcode = 7'd0;
        rs_full = '0; rob_full = 1'b0; rob_tail = '0; wb_valid = 1'b0; wb_preg = '0;
        flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_rn_ready", 128'(rn_ready), 128'd1);
        chk("reset_di_en", 128'(di_en), 128'd0);
        chk("reset_rob_alloc", 128'(rob_alloc), 128'd0);
        chk("reset_di_data", 128'(di_data), 128'd0);
        chk("reset_di_fu", 128'(di_fu), 128'd0);
        chk("reset_di_opcode", 128'(di_opcode), 128'd0);
        chk("reset_disp_cnt", 128'(dispatched_cnt), 128'd0);
        chk("reset_stall_cnt", 128'(stall_cnt), 128'd0);
        chk("reset_rtable", preg_rtable, {128{1'b1}});
        reset = 1'b0;

        // First dispatch to the ALU RS
        rob_tail = 5'd3;
        present(FU_ALU, 40, 5, 6);
        step();
        rn_valid = 1'b0;
        chk("t1_di_en", 128'(di_en), 128'b001);
        chk("t1_rob_idx", 128'(di_rob_index), 128'd3);
        chk("t1_rob_alloc", 128'(rob_alloc), 128'd1);
        chk("t1_ps1", 128'(di_data.ps1), 128'd5);
        chk("t1_ps2", 128'(di_data.ps2), 128'd6);
        step();
        chk("t1_bit40", 128'(preg_rtable[40]), 128'd0);
        chk("t1_disp_cnt", 128'(dispatched_cnt), 128'd1);
        chk("t1_idle_en", 128'(di_en), 128'd0);

        // LSU held against a full RS for four cycles
        rs_full = 3'b100;
        present(FU_LSU, 12, 1, 2);
        step();
        rn_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("t2_stall_en", 128'(di_en), 128'd0);
            chk("t2_stall_ready", 128'(rn_ready), 128'd0);
            step();
        end
        chk("t2_stall_cnt", 128'(stall_cnt), 128'd4);
        rs_full = 3'b000;
        #1;
        chk("t2_release_en", 128'(di_en), 128'b100);
        chk("t2_release_ready", 128'(rn_ready), 128'd1);
        step();
        chk("t2_disp_cnt", 128'(dispatched_cnt), 128'd2);
        chk("t2_stall_final", 128'(stall_cnt), 128'd4);

        // Back-to-back ALU then BR
        present(FU_ALU, 20, 1, 2);
        step();
        present(FU_BR, 21, 3, 4);
        chk("t3_first_en", 128'(di_en), 128'b001);
        chk("t3_first_ready", 128'(rn_ready), 128'd1);
        step();
        rn_valid = 1'b0;
        chk("t3_second_en", 128'(di_en), 128'b010);
        step();
        chk("t3_disp_cnt", 128'(dispatched_cnt), 128'd4);

        // Writeback bypass on a source woken in the dispatch cycle
        present(FU_ALU, 7, 1, 2);
        step();
        rn_valid = 1'b0;
        step();
        chk("t4_bit7_clear", 128'(preg_rtable[7]), 128'd0);
        present(FU_ALU, 0, 7, 2);
        step();
        rn_valid = 1'b0;
        wb_valid = 1'b1;
        wb_preg  = 7'd7;
        #1;
        chk("t4_bypass_en", 128'(di_en), 128'b001);
        chk("t4_bypass_bit7", 128'(preg_rtable[7]), 128'd1);
        step();
        wb_valid = 1'b0;
        #1;
        chk("t4_reg_bit7", 128'(preg_rtable[7]), 128'd1);
        chk("t4_bit0", 128'(preg_rtable[0]), 128'd1);

        // Clear beats set on the same preg
        present(FU_BR, 9, 1, 2);
        step();
        rn_valid = 1'b0;
        wb_valid = 1'b1;
        wb_preg  = 7'd9;
        #1;
        chk("t5_en", 128'(di_en), 128'b010);
        step();
        wb_valid = 1'b0;
        #1;
        chk("t5_bit9", 128'(preg_rtable[9]), 128'd0);
        chk("t5_disp_cnt", 128'(dispatched_cnt), 128'd7);

        // Flush a held instruction blocked by the ROB
        rob_full = 1'b1;
        present(FU_ALU, 30, 1, 2);
        step();
        rn_valid = 1'b0;
        flush = 1'b1;
        #1;
        chk("t6_flush_ready", 128'(rn_ready), 128'd0);
        chk("t6_flush_en", 128'(di_en), 128'd0);
        chk("t6_flush_alloc", 128'(rob_alloc), 128'd0);
        step();
        flush = 1'b0;
        rob_full = 1'b0;
        #1;
        chk("t6_after_alloc", 128'(rob_alloc), 128'd0);
        chk("t6_after_en", 128'(di_en), 128'd0);
        chk("t6_after_ready", 128'(rn_ready), 128'd1);
        step();
        chk("t6_still_alloc", 128'(rob_alloc), 128'd0);
        chk("t6_disp_cnt", 128'(dispatched_cnt), 128'd7);
        chk("t6_stall_cnt", 128'(stall_cnt), 128'd4);
        chk("t6_bit30", 128'(preg_rtable[30]), 128'd1);

        // ROB-only instruction
        present(FU_NONE, 33, 1, 2);
        step();
        rn_valid = 1'b0;
        chk("t7_alloc", 128'(rob_alloc), 128'd1);
        chk("t7_en", 128'(di_en), 128'd0);
        step();
        chk("t7_disp_cnt", 128'(dispatched_cnt), 128'd8);
        chk("t7_bit33", 128'(preg_rtable[33]), 128'd0);

        // Asynchronous reset mid-stall
        rs_full = 3'b001;
        present(FU_ALU, 50, 1, 2);
        step();
        rn_valid = 1'b0;
        step();
        chk("t8_pre_stall", 128'(stall_cnt), 128'd5);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("t8_rst_ready", 128'(rn_ready), 128'd1);
        chk("t8_rst_fu", 128'(di_data.pd_new), 128'd0);
        chk("t8_rst_stall", 128'(stall_cnt), 128'd0);
        chk("t8_rst_bit33", 128'(preg_rtable[33]), 128'd1);
        rs_full = 3'b000;
        #1;
        chk("t8_rst_en", 128'(di_en), 128'd0);
        step();
        reset = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/dispatch_unit.md
Name: dispatch_unit

Overview:
- Dispatch stage between rename and the three reservation stations (ALU, branch, LSU); the producing end of the RS dispatch interface.
- Buffers one renamed instruction and checks RS and ROB occupancy.
- Steers the instruction to the selected RS with a one-cycle enable pulse, allocates the ROB slot, and owns the physical-register ready table that every RS samples at dispatch.

Parameters:
- NUM_PREG, 128, physical registers; table depth and width of preg indices (7 bits).
- NUM_RS, 3, reservation stations; width of di_en and rs_full.
- ROB_IDX_W, 5, ROB index width.
- CNT_W, 16, width of the performance counters.

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- rn_valid  in  1  rename presents an instruction
- rn_ready  out  1  dispatch can accept this cycle
- rn_data  in  rename_data  renamed operands: pd_new, ps1, ps2, imm
- rn_fu  in  2  0=ALU, 1=branch, 2=LSU, 3=no-RS (ROB only)
- rn_opcode  in  7  opcode
- rs_full  in  NUM_RS  per-RS full flag
- di_en  out  NUM_RS  one-hot write enable to an RS
- di_data  out  rename_data  held operands to RS
- di_fu  out  2  held FU type
- di_opcode  out  7  held opcode
- rob_full  in  1  ROB cannot allocate
- rob_tail  in  ROB_IDX_W  next ROB slot
- rob_alloc  out  1  ROB allocate pulse
- di_rob_index  out  ROB_IDX_W  equals rob_tail while the holding register is valid
- wb_valid  in  1  writeback broadcast
- wb_preg  in  7  written physical register
- flush  in  1  mispredict flush; synchronous
- preg_rtable  out  NUM_PREG x1  ready bits, with writeback bypass
- dispatched_cnt  out  CNT_W  dispatched instructions
- stall_cnt  out  CNT_W  cycles with a held instruction blocked

Behaviour:
- Holding register: one entry, states EMPTY/FULL.
  - fire = FULL && !rob_full && (held fu==3 || !rs_full[held fu]).
  - rn_ready = EMPTY || fire; it is combinational.
  - Accept when rn_valid && rn_ready && !flush. The register goes FULL at the next edge, loaded with rn_*.
  - On fire without a new accept, go EMPTY. On fire with accept in the same cycle, stay FULL with the new contents; back-to-back throughput is 1 per cycle.
- Outputs:
  - di_en[f] = fire && (f == held fu); all zero when fu==3.
  - rob_alloc = fire.
  - di_* and di_rob_index come straight from the holding register and rob_tail.
  - Latency: accepted at cycle N, earliest di_en at cycle N+1.
- Ready table:
  - Reset: all bits 1.
  - On fire with pd_new != 0, clear bit pd_new at the edge.
  - On wb_valid, set bit wb_preg at the edge.
  - If the same preg is both cleared and set in one cycle, the clear wins.
  - Bit 0 is always 1 and writes to it are ignored.
- preg_rtable output = registered table OR decode(wb_valid, wb_preg). This bypass lets a source woken in the dispatch cycle be marked ready. An RS only wakes up entries that are already valid, so without the bypass that wakeup would be lost.
- flush: holding register goes EMPTY next edge; fire is suppressed that cycle (di_en=0, rob_alloc=0); rn_ready=0. The ready table is untouched.
- Counters:
  - dispatched_cnt increments on fire.
  - stall_cnt increments when FULL && !fire && !flush.
  - Both saturate at all-ones.
- Reset values:
  - State EMPTY, rn_ready=1, di_en=0, rob_alloc=0.
  - di_data, di_fu, di_opcode = 0.
  - Counters 0, table all 1.
- A reset assertion mid-stall discards the held instruction immediately (asynchronous).

Decomposition:
- types_pkg gains:
  - fu_type_e (FU_ALU=0, FU_BR=1, FU_LSU=2, FU_NONE=3);
  - constants NUM_PREG, ROB_IDX_W.
  - rename_data is reused unchanged.
- Sub-module preg_ready_table: registered table, set and clear ports, bypassed read-out. The holding register and steering logic stay in the top module.

Test Plan:
- After reset: rn_valid=1, fu=0, ps1=5, ps2=6, pd_new=40, rs_full=0, rob_tail=3 -> next cycle di_en=001, di_rob_index=3, rob_alloc=1, bit 40 of the table reads 0 one cycle later; dispatched_cnt=1.
- rs_full[2]=1 with a held LSU instruction for 4 cycles -> di_en=000, rn_ready=0, stall_cnt=4. Drop rs_full[2] -> di_en=100 the same cycle, rn_ready=1.
- Back-to-back ALU then BR with rs_full=0 for 2 cycles -> di_en=001 then 010 on consecutive cycles, no bubble.
- Table bit 7=0, wb_valid=1, wb_preg=7 in the same cycle a held instruction with ps1=7 fires -> preg_rtable[7]=1 that cycle; the registered bit is 1 afterwards.
- A held instruction with pd_new=9 fires while wb_valid=1, wb_preg=9 -> bit 9 = 0 after the edge.
- FULL with rob_full=1 and flush=1 -> next cycle EMPTY, no di_en or rob_alloc ever issued for that instruction, counters unchanged; fu=3 instruction -> rob_alloc=1, di_en=000.
